i2so_bist_check: RTL and testbench

- Self-test checker for the audio datapath: consumes 32-bit sample words plus a transfer-complete strobe, and verifies them against the sawtooth BIST pattern.
- The pattern runs start value, +increment, ... up to the limit, then wraps to the start value.
- Sits at the far end of the loop from the I2S-in BIST generator; reports lock, error count and pass status to the register file.

---
 rtl/i2s_bist_pkg.sv | 32 +++
 rtl/i2s_sat_cnt.sv | 23 ++
 rtl/i2so_bist_check.sv | 148 ++++++++++++++
 tb/tb_i2so_bist_check.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_bist_pkg.sv
// Shared definitions for the I2S BIST sawtooth generator/checker pair.
// Contents: state enum, datapath widths, pattern config struct and the
// next-value function nxt() shared by generator and checker.
package i2s_bist_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned VAL_W  = 12;
   localparam int unsigned INC_W  = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HUNT   = 2'd1,
      LOCKED = 2'd2
   } bist_state_e;

   // Pattern configuration as taken from the register file
   typedef struct packed {
      logic [VAL_W-1:0] start_val;
      logic [INC_W-1:0] inc;
      logic [VAL_W-1:0] up_limit;
   } bist_cfg_t;

   // Sawtooth step: wrap to start once the limit is reached, else add inc
   function automatic logic [DATA_W-1:0] nxt(input logic [DATA_W-1:0] v,
                                             input bist_cfg_t         cfg);
      if (v >= DATA_W'(cfg.up_limit))
         nxt = DATA_W'(cfg.start_val);
      else
         nxt = v + DATA_W'(cfg.inc);
   endfunction

endpackage

// File: rtl/i2s_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst (sync, active-high), inc (count enable),
//        clr (zero, priority over inc), cnt (registered count).
module i2s_sat_cnt #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc && (cnt != {W{1'b1}}))
         cnt <= cnt + W'(1);
   end

endmodule

// File: rtl/i2so_bist_check.sv
// Far-end checker for the audio BIST loop: verifies received sample words
// against the sawtooth pattern, tracks lock, error and word counts.
// Optional feature macro: I2SO_BIST_ERR_CAPTURE_EN (first-error capture).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rf_bist_chk_en           enable; low forces IDLE and drops strobes
//   rf_bist_start_val/inc/up_limit  pattern configuration
//   rf_bist_clr              pulse: clear counters and capture
//   chk_in_data, chk_in_xfc  sample word and its valid strobe
//   bist_locked, bist_err, bist_err_cnt, bist_word_cnt, bist_pass  status
//   bist_first_err_data/exp  first mismatch capture (feature only)
module i2so_bist_check
   import i2s_bist_pkg::*;
#(
   parameter int unsigned ERR_CNT_W     = 16,
   parameter int unsigned WORD_CNT_W    = 16,
   parameter int unsigned LOCK_LOSS_THR = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rf_bist_chk_en,
   input  logic [VAL_W-1:0]      rf_bist_start_val,
   input  logic [INC_W-1:0]      rf_bist_inc,
   input  logic [VAL_W-1:0]      rf_bist_up_limit,
   input  logic                  rf_bist_clr,
   input  logic [DATA_W-1:0]     chk_in_data,
   input  logic                  chk_in_xfc,
   output logic                  bist_locked,
   output logic                  bist_err,
   output logic [ERR_CNT_W-1:0]  bist_err_cnt,
   output logic [WORD_CNT_W-1:0] bist_word_cnt,
   output logic                  bist_pass
`ifdef I2SO_BIST_ERR_CAPTURE_EN
   ,
   output logic [DATA_W-1:0]     bist_first_err_data,
   output logic [DATA_W-1:0]     bist_first_err_exp
`endif
);

   localparam int unsigned MISS_W = 4;

   bist_state_e       state_q;
   logic [DATA_W-1:0] exp_q;
   logic [MISS_W-1:0] miss_cnt;
   bist_cfg_t         cfg;

   logic hunt_hit_c;
   logic lock_xfc_c;
   logic mism_c;
   logic lose_lock_c;
   logic locked_nxt_c;
   logic word_inc_c;

   assign cfg = '{start_val: rf_bist_start_val, inc: rf_bist_inc, up_limit: rf_bist_up_limit};

   // Strobe qualification and event decode
   assign hunt_hit_c  = rf_bist_chk_en && chk_in_xfc && (state_q == HUNT) &&
                        (chk_in_data == DATA_W'(rf_bist_start_val));
   assign lock_xfc_c  = rf_bist_chk_en && chk_in_xfc && (state_q == LOCKED);
   assign mism_c      = lock_xfc_c && (chk_in_data != exp_q);
   // This mismatch is the THR-th in a row; a concurrent clr resets the run instead
   assign lose_lock_c = mism_c && !rf_bist_clr &&
                        (miss_cnt == MISS_W'(LOCK_LOSS_THR - 1));
   assign locked_nxt_c = rf_bist_chk_en && (hunt_hit_c || ((state_q == LOCKED) && !lose_lock_c));
   // The word that acquires lock is counted as a checked word
   assign word_inc_c  = hunt_hit_c || lock_xfc_c;

   i2s_sat_cnt #(.W(ERR_CNT_W)) u_err_cnt (
      .clk (clk),
      .rst (rst),
      .inc (mism_c),
      .clr (rf_bist_clr),
      .cnt (bist_err_cnt)
   );

   i2s_sat_cnt #(.W(WORD_CNT_W)) u_word_cnt (
      .clk (clk),
      .rst (rst),
      .inc (word_inc_c),
      .clr (rf_bist_clr),
      .cnt (bist_word_cnt)
   );

   // Consecutive-miss run: restarts on any match and on lock acquisition
   i2s_sat_cnt #(.W(MISS_W)) u_miss_cnt (
      .clk (clk),
      .rst (rst),
      .inc (mism_c),
      .clr (rf_bist_clr || (lock_xfc_c && !mism_c) || hunt_hit_c),
      .cnt (miss_cnt)
   );

   // Checker FSM, expected-value register and registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         exp_q       <= '0;
         bist_err    <= 1'b0;
         bist_locked <= 1'b0;
         bist_pass   <= 1'b0;
      end else begin
         bist_err    <= mism_c && !rf_bist_clr;
         bist_locked <= locked_nxt_c;
         // Zero-ness of next counts derived from current counts and this cycle's events
         bist_pass   <= locked_nxt_c && !rf_bist_clr && !mism_c &&
                        ((bist_word_cnt != '0) || word_inc_c) && (bist_err_cnt == '0);
         if (!rf_bist_chk_en) begin
            state_q <= IDLE;
         end else begin
            case (state_q)
               IDLE: state_q <= HUNT;
               HUNT: begin
                  if (hunt_hit_c) begin
                     state_q <= LOCKED;
                     exp_q   <= nxt(DATA_W'(rf_bist_start_val), cfg);
                  end
               end
               LOCKED: begin
                  // Resync on the received word, matching or not
                  if (lock_xfc_c)
                     exp_q <= nxt(chk_in_data, cfg);
                  if (lose_lock_c)
                     state_q <= HUNT;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

`ifdef I2SO_BIST_ERR_CAPTURE_EN
   logic cap_done_q;

   // First-mismatch capture, re-armed by clr
   always_ff @(posedge clk) begin
      if (rst || rf_bist_clr) begin
         cap_done_q          <= 1'b0;
         bist_first_err_data <= '0;
         bist_first_err_exp  <= '0;
      end else if (mism_c && !cap_done_q) begin
         cap_done_q          <= 1'b1;
         bist_first_err_data <= chk_in_data;
         bist_first_err_exp  <= exp_q;
      end
   end
`endif

endmodule

// File: tb/tb_i2so_bist_check.sv
// Self-checking bench for i2so_bist_check with a spec-level reference model.
// Honours I2SO_BIST_ERR_CAPTURE_EN when defined.
module tb_i2so_bist_check;

   localparam int unsigned ERR_W  = 8;
   localparam int unsigned WORD_W = 10;
   localparam int unsigned THR    = 4;
   localparam int ERR_MAX  = (1 << ERR_W) - 1;
   localparam int WORD_MAX = (1 << WORD_W) - 1;
`ifdef I2SO_BIST_ERR_CAPTURE_EN
   localparam int unsigned OW = 1 + 1 + ERR_W + WORD_W + 1 + 64;
`else
   localparam int unsigned OW = 1 + 1 + ERR_W + WORD_W + 1;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              rf_bist_chk_en = 1'b0;
   logic [11:0]       cfg_start = 12'h010;
   logic [7:0]        cfg_inc = 8'h04;
   logic [11:0]       cfg_lim = 12'h020;
   logic              rf_bist_clr = 1'b0;
   logic [31:0]       chk_in_data = '0;
   logic              chk_in_xfc = 1'b0;
   logic              bist_locked;
   logic              bist_err;
   logic [ERR_W-1:0]  bist_err_cnt;
   logic [WORD_W-1:0] bist_word_cnt;
   logic              bist_pass;
`ifdef I2SO_BIST_ERR_CAPTURE_EN
   logic [31:0]       bist_first_err_data;
   logic [31:0]       bist_first_err_exp;
`endif

   i2so_bist_check #(
      .ERR_CNT_W     (ERR_W),
      .WORD_CNT_W    (WORD_W),
      .LOCK_LOSS_THR (THR)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .rf_bist_chk_en    (rf_bist_chk_en),
      .rf_bist_start_val (cfg_start),
      .rf_bist_inc       (cfg_inc),
      .rf_bist_up_limit  (cfg_lim),
      .rf_bist_clr       (rf_bist_clr),
      .chk_in_data       (chk_in_data),
      .chk_in_xfc        (chk_in_xfc),
      .bist_locked       (bist_locked),
      .bist_err          (bist_err),
      .bist_err_cnt      (bist_err_cnt),
      .bist_word_cnt     (bist_word_cnt),
      .bist_pass         (bist_pass)
`ifdef I2SO_BIST_ERR_CAPTURE_EN
      ,
      .bist_first_err_data (bist_first_err_data),
      .bist_first_err_exp  (bist_first_err_exp)
`endif
   );

   always #5 clk = ~clk;

   int n_run  = 0;
   int n_fail = 0;

   // Reference model state (0 = disabled, 1 = searching, 2 = tracking)
   int          m_state = 0;
   logic [31:0] m_exp   = '0;
   int          m_err   = 0;
   int          m_words = 0;
   int          m_miss  = 0;
   bit          m_pulse = 0;
   bit          m_cap_done = 0;
   logic [31:0] m_cap_d = '0;
   logic [31:0] m_cap_e = '0;

   logic [OW-1:0] dut_v;
`ifdef I2SO_BIST_ERR_CAPTURE_EN
   always_comb dut_v = {bist_locked, bist_err, bist_err_cnt, bist_word_cnt, bist_pass,
                        bist_first_err_data, bist_first_err_exp};
`else
   always_comb dut_v = {bist_locked, bist_err, bist_err_cnt, bist_word_cnt, bist_pass};
`endif

   function automatic logic [31:0] ref_nxt(input logic [31:0] v);
      if (v >= {20'd0, cfg_lim}) return {20'd0, cfg_start};
      return v + {24'd0, cfg_inc};
   endfunction

   function automatic logic [OW-1:0] model_v();
      bit lk, ps;
      lk = (m_state == 2);
      ps = (m_words != 0) && (m_err == 0) && lk;
`ifdef I2SO_BIST_ERR_CAPTURE_EN
      return {lk, m_pulse, ERR_W'(m_err), WORD_W'(m_words), ps, m_cap_d, m_cap_e};
`else
      return {lk, m_pulse, ERR_W'(m_err), WORD_W'(m_words), ps};
`endif
   endfunction

   // Spec-level behaviour of one clock cycle
   task automatic model(input bit r, input bit en, input bit clr, input bit x,
                        input logic [31:0] d);
      m_pulse = 0;
      if (r) begin
         m_state = 0; m_exp = '0; m_err = 0; m_words = 0; m_miss = 0;
         m_cap_done = 0; m_cap_d = '0; m_cap_e = '0;
         return;
      end
      if (!en) m_state = 0;
      else if (m_state == 0) m_state = 1;
      else if (m_state == 1) begin
         if (x && d == {20'd0, cfg_start}) begin
            m_state = 2; m_exp = ref_nxt(d); m_miss = 0;
            m_words = (m_words < WORD_MAX) ? m_words + 1 : WORD_MAX;
         end
      end else if (x) begin
         m_words = (m_words < WORD_MAX) ? m_words + 1 : WORD_MAX;
         if (d !== m_exp) begin
            m_err = (m_err < ERR_MAX) ? m_err + 1 : ERR_MAX;
            m_pulse = 1;
            m_miss++;
            if (!m_cap_done) begin
               m_cap_done = 1; m_cap_d = d; m_cap_e = m_exp;
            end
            if (m_miss >= THR && !clr) m_state = 1;
         end else begin
            m_miss = 0;
         end
         m_exp = ref_nxt(d);
      end
      if (clr) begin
         m_err = 0; m_words = 0; m_miss = 0; m_pulse = 0;
         m_cap_done = 0; m_cap_d = '0; m_cap_e = '0;
      end
   endtask

   // Drive one cycle of stimulus at the falling edge, return at the next one
   task automatic step(input bit r, input bit en, input bit clr, input bit x,
                       input logic [31:0] d);
      rst = r; rf_bist_chk_en = en; rf_bist_clr = clr; chk_in_xfc = x; chk_in_data = d;
      model(r, en, clr, x, d);
      @(negedge clk);
   endtask

   task automatic test_reset();
      step(1, 0, 0, 0, '0);
      step(1, 1, 0, 1, 32'h10);
      n_run++;
      if (dut_v !== model_v())
         $display("FAIL reset_state: got %h expected %h", dut_v, model_v());
      n_run++;
      if (bist_locked !== 1'b0 || bist_err_cnt !== '0 || bist_word_cnt !== '0 || bist_pass !== 1'b0)
         $display("FAIL reset_zero: got %h expected all zero", dut_v);
   endtask

   task automatic test_pattern();
      logic [31:0] words [8] = '{32'h05, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h10, 32'h14};
      cfg_start = 12'h010; cfg_inc = 8'h04; cfg_lim = 12'h020;
      step(0, 0, 0, 0, '0);
      step(0, 1, 0, 0, '0);
      foreach (words[i]) begin
         step(0, 1, 0, 1, words[i]);
         n_run++;
         if (dut_v !== model_v()) begin
            n_fail++;
            $display("FAIL pattern_w%0d: got %h expected %h", i, dut_v, model_v());
         end
      end
      n_run++;
      if (bist_err_cnt !== 8'd0 || bist_word_cnt !== 10'd7 || bist_pass !== 1'b1 || bist_locked !== 1'b1) begin
         n_fail++;
         $display("FAIL pattern_final: got err=%0d words=%0d pass=%b lock=%b expected 0/7/1/1",
                  bist_err_cnt, bist_word_cnt, bist_pass, bist_locked);
      end
   endtask

   task automatic test_error();
      logic [31:0] words [7] = '{32'h10, 32'h14, 32'h99, 32'h1C, 32'h20, 32'h10, 32'h14};
      int pulses = 0;
      step(0, 0, 1, 0, '0);
      step(0, 1, 0, 0, '0);
      foreach (words[i]) begin
         step(0, 1, 0, 1, words[i]);
         pulses += int'(bist_err);
         n_run++;
         if (dut_v !== model_v()) begin
            n_fail++;
            $display("FAIL error_w%0d: got %h expected %h", i, dut_v, model_v());
         end
      end
      n_run++;
      if (pulses != 2 || bist_err_cnt !== 8'd2 || bist_locked !== 1'b1 || bist_pass !== 1'b0) begin
         n_fail++;
         $display("FAIL error_final: got pulses=%0d err=%0d lock=%b pass=%b expected 2/2/1/0",
                  pulses, bist_err_cnt, bist_locked, bist_pass);
      end
`ifdef I2SO_BIST_ERR_CAPTURE_EN
      n_run++;
      if (bist_first_err_data !== 32'h99 || bist_first_err_exp !== 32'h18) begin
         n_fail++;
         $display("FAIL capture_first: got %h/%h expected 00000099/00000018",
                  bist_first_err_data, bist_first_err_exp);
      end
`endif
   endtask

   task automatic test_lock_loss();
      step(0, 1, 1, 0, '0);
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 0, 1, 32'h55);
         n_run++;
         if (bist_locked !== (i < 3) || dut_v !== model_v()) begin
            n_fail++;
            $display("FAIL lockloss_m%0d: got %h expected %h", i, dut_v, model_v());
         end
      end
      step(0, 1, 0, 1, 32'h10);
      n_run++;
      if (bist_locked !== 1'b1 || bist_err_cnt !== 8'd4 || dut_v !== model_v()) begin
         n_fail++;
         $display("FAIL relock: got %h expected %h", dut_v, model_v());
      end
   endtask

   task automatic test_clr_collision();
      logic [31:0] bad;
      step(0, 1, 0, 1, 32'h77);
      bad = 32'h0000_0011;
      step(0, 1, 1, 1, bad);
      n_run++;
      if (bist_err_cnt !== '0 || bist_word_cnt !== '0 || bist_err !== 1'b0 || dut_v !== model_v()) begin
         n_fail++;
         $display("FAIL clr_collision: got %h expected %h", dut_v, model_v());
      end
      step(0, 1, 0, 1, 32'h15);
      n_run++;
      if (bist_err !== 1'b0 || bist_word_cnt !== 10'd1 || dut_v !== model_v()) begin
         n_fail++;
         $display("FAIL clr_exp_update: got %h expected %h", dut_v, model_v());
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 300; i++) begin
         step(0, 1, 0, 1, m_exp ^ 32'h8000_0000);
         step(0, 1, 0, 1, m_exp);
      end
      n_run++;
      if (bist_err_cnt !== 8'hFF || bist_locked !== 1'b1 || dut_v !== model_v()) begin
         n_fail++;
         $display("FAIL err_saturate: got %h expected %h", dut_v, model_v());
      end
      for (int i = 0; i < 450; i++) step(0, 1, 0, 1, m_exp);
      n_run++;
      if (bist_word_cnt !== 10'h3FF || dut_v !== model_v()) begin
         n_fail++;
         $display("FAIL word_saturate: got %h expected %h", dut_v, model_v());
      end
   endtask

   task automatic test_disable_rst();
      step(0, 1, 1, 0, '0);
      step(0, 0, 0, 1, 32'hDEAD);
      n_run++;
      if (bist_locked !== 1'b0 || bist_err_cnt !== '0 || dut_v !== model_v()) begin
         n_fail++;
         $display("FAIL disable: got %h expected %h", dut_v, model_v());
      end
      step(0, 0, 0, 1, {20'd0, cfg_start});
      step(0, 1, 0, 1, {20'd0, cfg_start});
      n_run++;
      if (bist_word_cnt !== '0 || bist_locked !== 1'b0 || dut_v !== model_v()) begin
         n_fail++;
         $display("FAIL idle_drop: got %h expected %h", dut_v, model_v());
      end
      step(0, 1, 0, 1, {20'd0, cfg_start});
      step(0, 1, 0, 1, 32'h1234);
      n_run++;
      if (bist_locked !== 1'b1 || bist_err_cnt !== 8'd1 || dut_v !== model_v()) begin
         n_fail++;
         $display("FAIL pre_rst: got %h expected %h", dut_v, model_v());
      end
      step(1, 1, 0, 1, 32'h5678);
      n_run++;
      if (dut_v !== '0 || dut_v !== model_v()) begin
         n_fail++;
         $display("FAIL mid_rst: got %h expected %h", dut_v, model_v());
      end
   endtask

   task automatic test_random();
      bit en, clr, x;
      logic [31:0] d;
      for (int ep = 0; ep < 6; ep++) begin
         step(0, 0, 0, 0, '0);
         cfg_start = 12'($urandom);
         cfg_inc   = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
         cfg_lim   = 12'($urandom);
         step(0, 0, 1, 0, '0);
         for (int i = 0; i < 300; i++) begin
            en  = ($urandom_range(0, 99) != 0);
            clr = ($urandom_range(0, 49) == 0);
            x   = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
               0, 1:    d = 32'($urandom);
               2:       d = {20'd0, cfg_start};
               default: d = (m_state == 2) ? m_exp : {20'd0, cfg_start};
            endcase
            step(0, en, clr, x, d);
            n_run++;
            if (dut_v !== model_v()) begin
               n_fail++;
               $display("FAIL random_e%0d_c%0d: got %h expected %h", ep, i, dut_v, model_v());
            end
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_pattern();
      test_error();
      test_lock_loss();
      test_clr_collision();
      test_saturation();
      test_disable_rst();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
